// File: rtl/mfp_uart_rx_fifo.sv
// UART 8N1 receiver (16x oversampling) feeding a first-word-fall-through byte FIFO.
// Define MFP_UART_RX_PARITY_EN to expect an even parity bit between data and stop.
module mfp_uart_rx_fifo #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               rx_valid,
  output logic [FIFO_AW:0]   fifo_count,
  input  logic               err_clr,
  output logic               overrun,
  output logic               frame_err,
  output logic               parity_err,
  output logic               irq
);
  localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MFP_UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic               rx_meta_q, rx_s_q;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic               tick;
  logic [3:0]         os_q, os_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               push_q, push_d;
  logic [7:0]         push_data_q, push_data_d;
  logic               fe_set, pe_set;
  logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic               irq_q, irq_d;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push, do_pop, full;
`ifdef MFP_UART_RX_PARITY_EN
  logic               par_bad_q, par_bad_d;
  logic               parity_err_q, parity_err_d;
`endif

  // Two-flop synchroniser, preset to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Tick counter restarts on the start edge so bit centres line up with it.
  always_comb begin
    tick       = (tick_cnt_q == TW'(DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    if (state_q == IDLE && !rx_s_q) tick_cnt_d = '0;
  end

  always_comb begin
    state_d     = state_q;
    os_d        = os_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    fe_set      = 1'b0;
    pe_set      = 1'b0;
`ifdef MFP_UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        os_d    = '0;
      end
      START: if (tick) begin
        if (os_q == 4'd7) begin
          os_d      = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          os_d = os_q + 4'd1;
        end
      end
      DATA: if (tick) begin
        os_d = os_q + 4'd1;
        if (os_q == 4'd15) begin
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef MFP_UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef MFP_UART_RX_PARITY_EN
      PARITY: if (tick) begin
        os_d = os_q + 4'd1;
        if (os_q == 4'd15) begin
          par_bad_d = rx_s_q ^ (^shreg_q);
          pe_set    = par_bad_d;
          state_d   = STOP;
        end
      end
`endif
      STOP: if (tick) begin
        os_d = os_q + 4'd1;
        if (os_q == 4'd15) begin
          if (rx_s_q) begin
`ifdef MFP_UART_RX_PARITY_EN
            push_d = !par_bad_q;
`else
            push_d = 1'b1;
`endif
            push_data_d = shreg_q;
            state_d     = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO: a pop in the same cycle frees the slot for a push when full.
  always_comb begin
    full     = (count_q == (FIFO_AW+1)'(DEPTH));
    do_pop   = rd_en && (count_q != '0);
    do_push  = push_q && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
    overrun_d   = (push_q && !do_push) | (overrun_q & ~err_clr);
    frame_err_d = fe_set | (frame_err_q & ~err_clr);
`ifdef MFP_UART_RX_PARITY_EN
    parity_err_d = pe_set | (parity_err_q & ~err_clr);
    irq_d = (count_q != '0) | overrun_q | frame_err_q | parity_err_q;
`else
    irq_d = (count_q != '0) | overrun_q | frame_err_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      os_q        <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
`ifdef MFP_UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      os_q        <= os_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_q       <= irq_d;
`ifdef MFP_UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_q;
  end

  assign rx_valid   = (count_q != '0);
  assign rd_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign irq        = irq_q;
`ifdef MFP_UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
